d_reg_pipe: RTL and testbench

//   Parametrised successor to our single-bit enable/reset storage element: a DEPTH-stage, WIDTH-bit

---
 rtl/d_reg_pkg.sv | 12 +
 rtl/d_reg_stage.sv | 41 ++++
 rtl/d_reg_pipe.sv | 117 +++++++++++
 tb/tb_d_reg_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_reg_pkg.sv
// Shared helpers for the d_reg_pipe register pipeline: occupancy width and parameter sanity.
package d_reg_pkg;

    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned depth);
        return (width >= 1) && (depth >= 1);
    endfunction

endpackage

// File: rtl/d_reg_stage.sv
// One pipeline stage: a valid bit plus a WIDTH-bit data register with load enable and sync clear.
module d_reg_stage
    import d_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ld,
    input  logic             clr,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             v,
    output logic [WIDTH-1:0] q
);

    logic             v_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_q    <= 1'b0;
            data_q <= RESET_VAL;
        end else begin
            if (clr) begin
                v_q <= 1'b0;
            end else if (ld) begin
                v_q <= v_in;
            end
            // A bubble moving in leaves the old data in place.
            if (ld && v_in && !clr) begin
                data_q <= d_in;
            end
        end
    end

    assign v = v_q;
    assign q = data_q;

endmodule

// File: rtl/d_reg_pipe.sv
// DEPTH-stage valid/ready register pipeline with bubble collapsing, global enable and sync flush.
// Optional occupancy output enabled by defining D_REG_PIPE_OCC_EN.
module d_reg_pipe
    import d_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] D,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Q
`ifdef D_REG_PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occ
`endif
);

    if (!params_ok(WIDTH, DEPTH)) begin : g_bad_params
        $error("d_reg_pipe: WIDTH and DEPTH must both be at least 1");
    end

    logic                        adv;
    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0]            rdy;
    logic [DEPTH-1:0]            ld;
    logic [DEPTH-1:0]            v_in;
    logic [DEPTH-1:0][WIDTH-1:0] data;
    logic [DEPTH-1:0][WIDTH-1:0] d_in;

    assign adv = en & ~clr;

    // Stage i can move iff any stage at or after it is empty, or the sink takes the last word.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i] = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                if (!v[j]) begin
                    rdy[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        v_in[0] = in_valid;
        d_in[0] = D;
        for (int i = 1; i < DEPTH; i++) begin
            v_in[i] = v[i-1];
            d_in[i] = data[i-1];
        end
    end

    assign ld = {DEPTH{adv}} & rdy;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        d_reg_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk  (clk),
            .rstn (rstn),
            .ld   (ld[g]),
            .clr  (clr),
            .v_in (v_in[g]),
            .d_in (d_in[g]),
            .v    (v[g]),
            .q    (data[g])
        );
    end

    // Held low during reset so nothing upstream believes a word was taken.
    assign in_ready  = rstn & adv & rdy[0];
    assign out_valid = v[DEPTH-1];
    assign Q         = data[DEPTH-1];

`ifdef D_REG_PIPE_OCC_EN
    localparam int unsigned OccW = occ_width(DEPTH);

    logic [OccW-1:0] occ_q;
    logic [OccW-1:0] occ_d;
    logic            in_xfer;
    logic            out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready & adv;

    always_comb begin
        occ_d = occ_q;
        if (clr) begin
            occ_d = '0;
        end else if (in_xfer && !out_xfer) begin
            occ_d = occ_q + 1'b1;
        end else if (!in_xfer && out_xfer) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;
`endif

endmodule

// File: tb/tb_d_reg_pipe.sv
// Directed self-checking bench for d_reg_pipe; a DEPTH=4 and a DEPTH=1 instance share stimulus.
module tb_d_reg_pipe;

    logic       clk;
    logic       rstn;
    logic       en;
    logic       clr;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] D;

    logic       in_ready4, out_valid4, in_ready1, out_valid1;
    logic [7:0] q4, q1;
    logic       o_in_ready, o_valid;
    logic [7:0] o_q;
`ifdef D_REG_PIPE_OCC_EN
    logic [2:0] occ4;
    logic [0:0] occ1;
    logic [2:0] o_occ;
`endif

    int   sel;
    int   dep;
    int   passes, checks;
    int   edge_cnt;
    int   ni, no;
    int   first_acc, first_out, last_out;
    logic acc;

    d_reg_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) u_dut4 (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready4),
        .D         (D),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .Q         (q4)
`ifdef D_REG_PIPE_OCC_EN
        ,
        .occ       (occ4)
`endif
    );

    d_reg_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'hA5)) u_dut1 (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .D         (D),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .Q         (q1)
`ifdef D_REG_PIPE_OCC_EN
        ,
        .occ       (occ1)
`endif
    );

    assign o_in_ready = (sel != 0) ? in_ready1 : in_ready4;
    assign o_valid    = (sel != 0) ? out_valid1 : out_valid4;
    assign o_q        = (sel != 0) ? q1 : q4;
`ifdef D_REG_PIPE_OCC_EN
    assign o_occ      = (sel != 0) ? {2'b00, occ1} : occ4;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        en        = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        D         = 8'h00;
        step();
        step();
        rstn      = 1'b1;
        ni        = 0;
        no        = 0;
        first_acc = -1;
        first_out = -1;
        last_out  = -1;
    endtask

    // Offer words 1..n in order and check every word leaving the pipe against the same sequence.
    task automatic pump(input int n, input int max_c);
        for (int c = 0; c < max_c && no < n; c++) begin
            if (o_valid && out_ready) begin
                if (first_out < 0) first_out = edge_cnt;
                last_out = edge_cnt;
                checks++;
                if (o_q !== 8'(no + 1))
                    $display("FAIL order[%0d] d%0d: got %h expected %h", no, dep, o_q, 8'(no + 1));
                else passes++;
                no++;
            end
            in_valid = (ni < n);
            D        = 8'(ni + 1);
            #1;
            acc = in_valid && o_in_ready;
            step();
            if (acc) begin
                if (first_acc < 0) first_acc = edge_cnt;
                ni++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b1; clr = 1'b0; in_valid = 1'b1; D = 8'hFF; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", o_valid);
            else passes++;
            checks++;
            if (o_q !== 8'hA5) $display("FAIL reset_q: got %h expected a5", o_q);
            else passes++;
            checks++;
            if (o_in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", o_in_ready);
            else passes++;
        end
`ifdef D_REG_PIPE_OCC_EN
        checks++;
        if (o_occ !== 3'd0) $display("FAIL reset_occ: got %0d expected 0", o_occ);
        else passes++;
`endif
        in_valid = 1'b0;
        rstn     = 1'b1;
        #1;
        checks++;
        if (o_in_ready !== 1'b1) $display("FAIL release_in_ready: got %b expected 1", o_in_ready);
        else passes++;
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        pump(16, 40);
        checks++;
        if (no != 16) $display("FAIL stream_count d%0d: got %0d expected 16", dep, no);
        else passes++;
        checks++;
        if (first_out - first_acc != dep - 1)
            $display("FAIL stream_latency d%0d: got %0d expected %0d",
                     dep, first_out - first_acc, dep - 1);
        else passes++;
        checks++;
        if (last_out - first_out != 15)
            $display("FAIL stream_rate d%0d: got %0d expected 15", dep, last_out - first_out);
        else passes++;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            D        = 8'(ni + 1);
            #1;
            acc = o_in_ready;
            step();
            if (acc) ni++;
        end
        checks++;
        if (ni != dep) $display("FAIL full_accepted d%0d: got %0d expected %0d", dep, ni, dep);
        else passes++;
        checks++;
        if (o_in_ready !== 1'b0) $display("FAIL full_in_ready d%0d: got %b expected 0", dep, o_in_ready);
        else passes++;
        checks++;
        if (o_valid !== 1'b1 || o_q !== 8'h01)
            $display("FAIL full_head d%0d: got %b/%h expected 1/01", dep, o_valid, o_q);
        else passes++;
`ifdef D_REG_PIPE_OCC_EN
        checks++;
        if (int'(o_occ) != dep) $display("FAIL full_occ d%0d: got %0d expected %0d", dep, o_occ, dep);
        else passes++;
`endif
        step();
        checks++;
        if (o_q !== 8'h01) $display("FAIL full_stable d%0d: got %h expected 01", dep, o_q);
        else passes++;
        out_ready = 1'b1;
        pump(5, 20);
        checks++;
        if (no != 5) $display("FAIL drain_count d%0d: got %0d expected 5", dep, no);
        else passes++;
    endtask

    task automatic test_bubble();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        D         = 8'hAA;
        step();
        in_valid  = 1'b0;
        step();
        step();
        in_valid  = 1'b1;
        D         = 8'hBB;
        step();
        in_valid  = 1'b0;
        step();
        step();
        step();
        checks++;
        if (o_valid !== 1'b1 || o_q !== 8'hAA)
            $display("FAIL bubble_head: got %b/%h expected 1/aa", o_valid, o_q);
        else passes++;
        checks++;
        if (o_in_ready !== 1'b1) $display("FAIL bubble_in_ready: got %b expected 1", o_in_ready);
        else passes++;
`ifdef D_REG_PIPE_OCC_EN
        checks++;
        if (o_occ !== 3'd2) $display("FAIL bubble_occ: got %0d expected 2", o_occ);
        else passes++;
`endif
        out_ready = 1'b1;
        step();
        checks++;
        if (o_valid !== 1'b1 || o_q !== 8'hBB)
            $display("FAIL bubble_second: got %b/%h expected 1/bb", o_valid, o_q);
        else passes++;
        step();
        checks++;
        if (o_valid !== 1'b0) $display("FAIL bubble_empty: got %b expected 0", o_valid);
        else passes++;
    endtask

    task automatic test_en_clr();
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < dep + 2; c++) begin
            in_valid = 1'b1;
            D        = 8'(ni + 1);
            #1;
            acc = o_in_ready;
            step();
            if (acc) ni++;
        end
        en        = 1'b0;
        in_valid  = 1'b1;
        D         = 8'h77;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (o_in_ready !== 1'b0) $display("FAIL en_in_ready d%0d: got %b expected 0", dep, o_in_ready);
            else passes++;
            step();
            checks++;
            if (o_valid !== 1'b1 || o_q !== 8'h01)
                $display("FAIL en_hold d%0d: got %b/%h expected 1/01", dep, o_valid, o_q);
            else passes++;
`ifdef D_REG_PIPE_OCC_EN
            checks++;
            if (int'(o_occ) != dep) $display("FAIL en_occ d%0d: got %0d expected %0d", dep, o_occ, dep);
            else passes++;
`endif
        end
        en  = 1'b1;
        clr = 1'b1;
        #1;
        checks++;
        if (o_in_ready !== 1'b0) $display("FAIL clr_in_ready d%0d: got %b expected 0", dep, o_in_ready);
        else passes++;
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_q !== 8'h01)
            $display("FAIL clr_flush d%0d: got %b/%h expected 0/01", dep, o_valid, o_q);
        else passes++;
`ifdef D_REG_PIPE_OCC_EN
        checks++;
        if (o_occ !== 3'd0) $display("FAIL clr_occ d%0d: got %0d expected 0", dep, o_occ);
        else passes++;
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b1;
        pump(16, 6);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_q !== 8'hA5)
            $display("FAIL async_reset: got %b/%h expected 0/a5", o_valid, o_q);
        else passes++;
`ifdef D_REG_PIPE_OCC_EN
        checks++;
        if (o_occ !== 3'd0) $display("FAIL async_occ: got %0d expected 0", o_occ);
        else passes++;
`endif
        #2;
        rstn = 1'b1;
        step();
        checks++;
        if (o_valid !== 1'b0 || o_q !== 8'hA5)
            $display("FAIL async_after: got %b/%h expected 0/a5", o_valid, o_q);
        else passes++;
    endtask

    initial begin
        passes   = 0;
        checks   = 0;
        edge_cnt = 0;
        sel      = 0;
        dep      = 4;
        test_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_en_clr();
        test_async_reset();
        sel = 1;
        dep = 1;
        test_stream();
        test_backpressure();
        test_en_clr();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
